// File: rtl/dda_uart_ctrl.sv
// Byte-level command controller between the UART byte side and the DDA core.
// Optional trailing XOR checksum on W frames is enabled by defining CHECKSUM_EN.
module dda_uart_ctrl #(
    parameter int REG_BYTES   = 10,
    parameter int OUT_BYTES   = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [7:0]             tx_byte,
    input  logic [8*OUT_BYTES-1:0] state_in,
    output logic [8*REG_BYTES-1:0] params,
    output logic                   dda_en,
    output logic                   busy,
    output logic                   err
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR       = 3'd1;
    localparam logic [2:0] ST_COMMIT   = 3'd2;
    localparam logic [2:0] ST_STEP_CNT = 3'd3;
    localparam logic [2:0] ST_STEPPING = 3'd4;
    localparam logic [2:0] ST_TX       = 3'd5;
    localparam logic [2:0] ST_RESP     = 3'd6;
`ifdef CHECKSUM_EN
    localparam logic [2:0] ST_CSUM     = 3'd7;
`endif

    localparam logic [7:0]  CMD_W    = 8'h57;
    localparam logic [7:0]  CMD_R    = 8'h52;
    localparam logic [7:0]  CMD_S    = 8'h53;
    localparam logic [7:0]  CMD_C    = 8'h43;
    localparam logic [7:0]  ACK      = 8'h06;
    localparam logic [7:0]  NAK      = 8'h15;
    localparam logic [7:0]  LAST_REG = 8'(REG_BYTES - 1);
    localparam logic [7:0]  LAST_OUT = 8'(OUT_BYTES - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

`ifdef CHECKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [8*REG_BYTES-1:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < REG_BYTES; i++) acc = acc ^ v[8*i +: 8];
        return acc;
    endfunction
`endif

    logic [1:0]             rst_sync_q;
    logic                   rst_int_n_s;
    logic [2:0]             state_q, state_d;
    logic [7:0]             idx_q, idx_d;
    logic [8*REG_BYTES-1:0] shadow_q, shadow_d;
    logic [8*REG_BYTES-1:0] params_q, params_d;
    logic [8*OUT_BYTES-1:0] snap_q, snap_d;
    logic [7:0]             step_q, step_d;
    logic [31:0]            tmo_q, tmo_d;
    logic [7:0]             resp_q, resp_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   dda_en_q, dda_en_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   err_set_s, err_clr_s, timed_s, timeout_s;

    // Reset asserts asynchronously and releases synchronously to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n_s = rst_sync_q[1];

    // Next-state, datapath and response sequencing.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        params_d   = params_q;
        snap_d     = snap_q;
        step_d     = step_q;
        resp_d     = resp_q;
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        dda_en_d   = 1'b0;
        err_set_s  = 1'b0;
        err_clr_s  = 1'b0;
        timeout_s  = 1'b0;

        timed_s = (state_q == ST_WR) || (state_q == ST_STEP_CNT);
`ifdef CHECKSUM_EN
        timed_s = timed_s || (state_q == ST_CSUM);
`endif
        if (!timed_s || rx_valid) begin
            tmo_d = 32'd0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d     = 32'd0;
            timeout_s = 1'b1;
        end else begin
            tmo_d = tmo_q + 32'd1;
        end

        // Bytes arriving while the controller cannot accept them are dropped.
        if (rx_valid && (state_q == ST_STEPPING || state_q == ST_TX ||
                         state_q == ST_RESP || state_q == ST_COMMIT)) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_byte)
                        CMD_W: begin state_d = ST_WR; idx_d = 8'd0; end
                        CMD_R: begin state_d = ST_TX; idx_d = 8'd0; snap_d = state_in; end
                        CMD_S: state_d = ST_STEP_CNT;
                        CMD_C: begin err_clr_s = 1'b1; resp_d = ACK; state_d = ST_RESP; end
                        default: begin err_set_s = 1'b1; resp_d = NAK; state_d = ST_RESP; end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (timeout_s) begin
                    err_set_s = 1'b1;
                    shadow_d  = '0;
                    idx_d     = 8'd0;
                    state_d   = ST_IDLE;
                end else if (rx_valid) begin
                    for (int i = 0; i < REG_BYTES; i++) begin
                        if (idx_q == 8'(i)) shadow_d[8*(REG_BYTES-1-i) +: 8] = rx_byte;
                    end
                    if (idx_q == LAST_REG) begin
                        idx_d = 8'd0;
`ifdef CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_COMMIT;
`endif
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else begin
                    state_d = ST_WR;
                end
            end
`ifdef CHECKSUM_EN
            ST_CSUM: begin
                if (timeout_s) begin
                    err_set_s = 1'b1;
                    shadow_d  = '0;
                    state_d   = ST_IDLE;
                end else if (rx_valid) begin
                    if (rx_byte == xor_bytes(shadow_q)) begin
                        state_d = ST_COMMIT;
                    end else begin
                        err_set_s = 1'b1;
                        shadow_d  = '0;
                        resp_d    = NAK;
                        state_d   = ST_RESP;
                    end
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif
            ST_COMMIT: begin
                params_d = shadow_q;
                resp_d   = ACK;
                state_d  = ST_RESP;
            end
            ST_STEP_CNT: begin
                if (timeout_s) begin
                    err_set_s = 1'b1;
                    state_d   = ST_IDLE;
                end else if (rx_valid) begin
                    if (rx_byte == 8'd0) begin
                        resp_d  = ACK;
                        state_d = ST_RESP;
                    end else begin
                        step_d   = rx_byte - 8'd1;
                        dda_en_d = 1'b1;
                        state_d  = ST_STEPPING;
                    end
                end else begin
                    state_d = ST_STEP_CNT;
                end
            end
            // step_q holds the steps still owed after the current high cycle.
            ST_STEPPING: begin
                if (step_q != 8'd0) begin
                    step_d   = step_q - 8'd1;
                    dda_en_d = 1'b1;
                end else begin
                    resp_d  = ACK;
                    state_d = ST_RESP;
                end
            end
            ST_TX: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    for (int i = 0; i < OUT_BYTES; i++) begin
                        if (idx_q == 8'(i)) tx_byte_d = snap_q[8*(OUT_BYTES-1-i) +: 8];
                    end
                end else if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (idx_q == LAST_OUT) begin
                        idx_d   = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else begin
                    tx_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_byte_d  = resp_q;
                end else if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    tx_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (err_set_s)      err_d = 1'b1;
        else if (err_clr_s) err_d = 1'b0;
        else                err_d = err_q;

        busy_d = (state_d != ST_IDLE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_q    <= ST_IDLE;
            idx_q      <= 8'd0;
            shadow_q   <= '0;
            params_q   <= '0;
            snap_q     <= '0;
            step_q     <= 8'd0;
            tmo_q      <= 32'd0;
            resp_q     <= 8'd0;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= 8'd0;
            dda_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            params_q   <= params_d;
            snap_q     <= snap_d;
            step_q     <= step_d;
            tmo_q      <= tmo_d;
            resp_q     <= resp_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
            dda_en_q   <= dda_en_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_byte  = tx_byte_q;
    assign params   = params_q;
    assign dda_en   = dda_en_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dda_uart_ctrl.sv
// Self-checking bench for dda_uart_ctrl: directed scenarios plus randomized
// commands compared against a byte-level reference model.
module tb_dda_uart_ctrl;
    localparam int RB  = 10;
    localparam int OB  = 4;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst_n, rx_valid, tx_valid, tx_ready, dda_en, busy, err;
    logic [7:0]    rx_byte, tx_byte;
    logic [8*OB-1:0] state_in;
    logic [8*RB-1:0] params;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mp[RB];
    logic [7:0] wbuf[RB];
    bit         err_m;
    int         en_total = 0;
    int         en_runs = 0;
    bit         en_prev = 1'b0;
    bit         pend = 1'b0;
    logic [7:0] pend_byte = 8'h00;

    dda_uart_ctrl #(.REG_BYTES(RB), .OUT_BYTES(OB), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
        .state_in(state_in), .params(params), .dda_en(dda_en), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Collect accepted bytes, check held bytes, measure dda_en pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend    = 1'b0;
            en_prev = 1'b0;
        end else begin
            if (pend) begin
                checks++;
                assert ({tx_valid, tx_byte} === {1'b1, pend_byte}) else begin
                    errors++;
                    $error("FAIL tx_hold: observed %b/%h expected 1/%h", tx_valid, tx_byte, pend_byte);
                end
            end
            if (tx_valid && tx_ready) got_q.push_back(tx_byte);
            pend      = tx_valid && !tx_ready;
            pend_byte = tx_byte;
            if (dda_en) begin
                en_total++;
                if (!en_prev) en_runs++;
            end
            en_prev = dda_en;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    function automatic logic [8*RB-1:0] model_params();
        logic [8*RB-1:0] r;
        for (int i = 0; i < RB; i++) r[8*(RB-1-i) +: 8] = mp[i];
        return r;
    endfunction

    task automatic send_w();
        logic [7:0] x;
        x = 8'h00;
        send_byte(8'h57);
        for (int i = 0; i < RB; i++) begin
            send_byte(wbuf[i]);
            x = x ^ wbuf[i];
        end
`ifdef CHECKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic wait_idle(input bit rnd);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            tick(1);
            n++;
        end
        tx_ready = 1'b1;
        if (n >= 5000) check("idle_budget", 128'(n), 128'(0));
    endtask

    task automatic compare_tx(input string tag);
        check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_byte"}, 128'(got_q[i]), 128'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_params"}, 128'(params), 128'(model_params()));
        check({tag, "_err"}, 128'(err), 128'(err_m));
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] st;
        int          n, op;

        rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b1; state_in = '0;
        err_m = 1'b0;
        for (int i = 0; i < RB; i++) mp[i] = 8'h00;
        #12;
        check("reset_outs", {tx_valid, tx_byte, dda_en, busy, err}, 128'd0);
        check("reset_params", 128'(params), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(4);

        // Directed write 01..0A.
        for (int i = 0; i < RB; i++) wbuf[i] = 8'(i + 1);
        send_byte(8'h57);
        check("w_busy", 128'(busy), 128'd1);
        for (int i = 0; i < RB; i++) send_byte(wbuf[i]);
`ifdef CHECKSUM_EN
        send_byte(8'h0B);
`endif
        for (int i = 0; i < RB; i++) mp[i] = wbuf[i];
        exp_q.push_back(8'h06);
        wait_idle(1'b0);
        check("w_params_literal", 128'(params), 128'h0102030405060708090A);
        compare_tx("w_ack");
        check_model("w");

`ifdef CHECKSUM_EN
        send_byte(8'h57);
        for (int i = 0; i < RB; i++) send_byte(8'(i + 1) ^ 8'h80);
        send_byte(8'h00);
        err_m = 1'b1;
        exp_q.push_back(8'h15);
        wait_idle(1'b0);
        compare_tx("csum_bad");
        check_model("csum_bad");
        send_byte(8'h43);
        err_m = 1'b0;
        exp_q.push_back(8'h06);
        wait_idle(1'b0);
        compare_tx("csum_clr");
`endif

        // Snapshot read with stalled receiver.
        state_in = 32'hDEADBEEF;
        tx_ready = 1'b0;
        send_byte(8'h52);
        state_in = 32'h12345678;
        check("r_lat1", 128'(tx_valid), 128'd0);
        tick(1);
        check("r_lat2", {tx_valid, tx_byte}, {1'b1, 8'hDE});
        tick(4);
        check("r_stall", {tx_valid, tx_byte}, {1'b1, 8'hDE});
        tx_ready = 1'b1;
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        wait_idle(1'b0);
        compare_tx("r");

        // Counted stepping, n=5 then n=0.
        en_total = 0; en_runs = 0;
        send_byte(8'h53);
        send_byte(8'h05);
        check("s5_start", 128'(dda_en), 128'd1);
        exp_q.push_back(8'h06);
        wait_idle(1'b0);
        check("s5_steps", 128'(en_total), 128'd5);
        check("s5_runs", 128'(en_runs), 128'd1);
        compare_tx("s5");
        en_total = 0; en_runs = 0;
        send_byte(8'h53);
        send_byte(8'h00);
        exp_q.push_back(8'h06);
        wait_idle(1'b0);
        check("s0_steps", 128'(en_total), 128'd0);
        compare_tx("s0");

        // Inter-byte timeout.
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        tick(TMO - 3);
        check("tmo_before", {busy, err}, 128'b10);
        tick(5);
        err_m = 1'b1;
        check("tmo_after", {busy, err, tx_valid}, 128'b010);
        compare_tx("tmo_silent");
        check_model("tmo");
        send_byte(8'h43);
        check("c_lat1", 128'(tx_valid), 128'd0);
        tick(1);
        check("c_lat2", {tx_valid, tx_byte}, {1'b1, 8'h06});
        err_m = 1'b0;
        exp_q.push_back(8'h06);
        wait_idle(1'b0);
        compare_tx("c");
        check_model("c");

        // Unknown opcode.
        send_byte(8'h7F);
        err_m = 1'b1;
        exp_q.push_back(8'h15);
        wait_idle(1'b0);
        compare_tx("nak");
        check_model("nak");
        send_byte(8'h43);
        err_m = 1'b0;
        exp_q.push_back(8'h06);
        wait_idle(1'b0);
        compare_tx("nak_clr");

        // Overrun while stepping n=20.
        en_total = 0; en_runs = 0;
        send_byte(8'h53);
        send_byte(8'd20);
        tick(5);
        send_byte(8'h57);
        err_m = 1'b1;
        exp_q.push_back(8'h06);
        wait_idle(1'b0);
        check("ovr_steps", 128'(en_total), 128'd20);
        check("ovr_runs", 128'(en_runs), 128'd1);
        compare_tx("ovr");
        check_model("ovr");

        // Randomized command mix against the model.
        for (int it = 0; it < 16; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    for (int i = 0; i < RB; i++) wbuf[i] = 8'($urandom);
                    send_w();
                    for (int i = 0; i < RB; i++) mp[i] = wbuf[i];
                    exp_q.push_back(8'h06);
                end
                1: begin
                    st = $urandom;
                    state_in = st;
                    send_byte(8'h52);
                    state_in = $urandom;
                    for (int i = 0; i < OB; i++) exp_q.push_back(8'(st >> (8 * (OB - 1 - i))));
                end
                2: begin
                    n = $urandom_range(0, 12);
                    en_total = 0; en_runs = 0;
                    send_byte(8'h53);
                    send_byte(8'(n));
                    exp_q.push_back(8'h06);
                end
                3: begin
                    do b = 8'($urandom); while (b == 8'h57 || b == 8'h52 || b == 8'h53 || b == 8'h43);
                    send_byte(b);
                    err_m = 1'b1;
                    exp_q.push_back(8'h15);
                end
                default: begin
                    send_byte(8'h43);
                    err_m = 1'b0;
                    exp_q.push_back(8'h06);
                end
            endcase
            wait_idle(1'b1);
            if (op == 2) check("rnd_steps", 128'(en_total), 128'(n));
            compare_tx("rnd");
            check_model("rnd");
        end

        // Reset in the middle of a frame.
        send_byte(8'h57);
        for (int i = 0; i < 3; i++) send_byte(8'h5A);
        rst_n = 1'b0;
        #2;
        check("rst_mid_params", 128'(params), 128'd0);
        check("rst_mid_outs", {tx_valid, dda_en, busy, err}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
